// File: rtl/branch_pht.sv
// Pattern-history table of saturating counters with optional gshare indexing and a clear sweep.
// Predictions read combinationally; updates land on the next edge; busy blocks updates during the sweep.
module branch_pht #(
  parameter int INDEX_W  = 6,
  parameter int CTR_W    = 2,
  parameter int INIT_CTR = 1,
  parameter int GSHARE   = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic [INDEX_W-1:0] pred_pc,
  output logic               pred_taken,
  output logic [CTR_W-1:0]   pred_ctr,
  output logic [INDEX_W-1:0] pred_index,
  input  logic               upd_valid,
  input  logic [INDEX_W-1:0] upd_index,
  input  logic               upd_taken,
  output logic               busy
);

  localparam int               DEPTH   = 1 << INDEX_W;
  localparam logic [CTR_W-1:0] INIT_V  = CTR_W'(INIT_CTR);
  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state_q, state_d;
  logic [INDEX_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [INDEX_W-1:0] ghr_q, ghr_d;
  logic [CTR_W-1:0]   mem_q [DEPTH];
  logic [CTR_W-1:0]   mem_d [DEPTH];
  logic [CTR_W-1:0]   upd_cur;
  logic [CTR_W-1:0]   upd_nxt;

  // ghr stays zero without gshare, so the XOR degenerates to the plain PC index
  assign pred_index = pred_pc ^ ghr_q;
  assign busy       = (state_q == CLEAR);
  assign pred_ctr   = busy ? INIT_V : mem_q[pred_index];
  assign pred_taken = pred_ctr[CTR_W-1];

  always_comb begin
    upd_cur = mem_q[upd_index];
    upd_nxt = upd_cur;
    if (upd_taken) begin
      if (upd_cur != CTR_MAX) upd_nxt = upd_cur + CTR_W'(1);
    end else begin
      if (upd_cur != '0) upd_nxt = upd_cur - CTR_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    ghr_d     = ghr_q;
    mem_d     = mem_q;
    if (reset || flush) begin
      // an update in the same cycle is dropped along with the sweep restart
      state_d   = CLEAR;
      clr_ptr_d = '0;
      ghr_d     = '0;
    end else if (state_q == CLEAR) begin
      mem_d[clr_ptr_q] = INIT_V;
      clr_ptr_d        = clr_ptr_q + INDEX_W'(1);
      if (clr_ptr_q == {INDEX_W{1'b1}}) state_d = IDLE;
    end else if (upd_valid) begin
      mem_d[upd_index] = upd_nxt;
      if (GSHARE != 0) ghr_d = {ghr_q[INDEX_W-2:0], upd_taken};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      ghr_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ghr_q     <= ghr_d;
    end
  end

  // table contents are reinitialised by the sweep, so no reset here
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_branch_pht.sv
// Scoreboard bench for branch_pht: default, gshare and single-bit instances share stimulus.
module tb_branch_pht;

  logic       clk = 1'b0;
  logic       rst_a = 1'b0, rst_g = 1'b0, rst_c = 1'b0;
  logic       flush = 1'b0;
  logic [5:0] pred_pc = '0;
  logic       upd_valid = 1'b0;
  logic [5:0] upd_index = '0;
  logic       upd_taken = 1'b0;

  logic       a_taken, g_taken, c_taken;
  logic [1:0] a_ctr, g_ctr;
  logic [0:0] c_ctr;
  logic [5:0] a_index, g_index, c_index;
  logic       a_busy, g_busy, c_busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string tag;
    int    val;
  } sb_t;
  sb_t exp_q[$];

  always #5 clk = ~clk;

  branch_pht #(.INDEX_W(6), .CTR_W(2), .INIT_CTR(1), .GSHARE(0)) u_dflt (
    .clk(clk), .reset(rst_a), .flush(flush), .pred_pc(pred_pc),
    .pred_taken(a_taken), .pred_ctr(a_ctr), .pred_index(a_index),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken), .busy(a_busy));

  branch_pht #(.INDEX_W(6), .CTR_W(2), .INIT_CTR(1), .GSHARE(1)) u_gsh (
    .clk(clk), .reset(rst_g), .flush(1'b0), .pred_pc(pred_pc),
    .pred_taken(g_taken), .pred_ctr(g_ctr), .pred_index(g_index),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken), .busy(g_busy));

  branch_pht #(.INDEX_W(6), .CTR_W(1), .INIT_CTR(0), .GSHARE(0)) u_c1 (
    .clk(clk), .reset(rst_c), .flush(1'b0), .pred_pc(pred_pc),
    .pred_taken(c_taken), .pred_ctr(c_ctr), .pred_index(c_index),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken), .busy(c_busy));

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int val);
    sb_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input int obs);
    sb_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_underflow: got %0d, expected a queued value", obs);
    end else begin
      e = exp_q.pop_front();
      check_eq(e.tag, obs, e.val);
    end
  endtask

  function automatic int a_pred();
    return int'({a_taken, a_ctr});
  endfunction

  function automatic logic busy_of(input int which);
    case (which)
      0:       return a_busy;
      1:       return g_busy;
      default: return c_busy;
    endcase
  endfunction

  // Starts at a negedge; counts busy samples, optionally pulsing an update mid-sweep.
  task automatic count_busy(input int which, input int inject_at, output int cnt);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (!busy_of(which)) break;
      cnt++;
      if (which == 0 && cnt == 1) begin
        sb_push("busy_masks_ctr", 1);
        sb_pop(a_pred());
      end
      if (cnt == inject_at) begin
        upd_valid = 1'b1;
        upd_index = 6'd3;
        upd_taken = 1'b0;
      end else begin
        upd_valid = 1'b0;
      end
      @(negedge clk);
    end
    upd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cnt;
    logic [6:0] sat_seq [7];
    int         sat_exp [7];

    // reset and initial sweep of the default table
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    sb_push("busy_after_reset", 1);
    sb_pop(int'(a_busy));
    count_busy(0, -1, cnt);
    sb_push("reset_sweep_len", 64);
    sb_pop(cnt);

    for (int pc = 0; pc < 64; pc++) begin
      pred_pc = 6'(pc);
      #1;
      sb_push($sformatf("init_pc%0d", pc), 1);
      sb_pop(a_pred());
    end

    // back-to-back saturating updates on index 5
    sat_seq = '{1, 1, 1, 0, 0, 0, 0};
    sat_exp = '{6, 7, 7, 6, 1, 0, 0};
    pred_pc   = 6'd5;
    upd_index = 6'd5;
    for (int i = 0; i < 7; i++) begin
      upd_valid = 1'b1;
      upd_taken = sat_seq[i][0];
      @(negedge clk);
      sb_push($sformatf("sat_step%0d", i), sat_exp[i]);
      sb_pop(a_pred());
    end
    upd_valid = 1'b0;

    // same-cycle read and update of index 9: no bypass
    pred_pc   = 6'd9;
    upd_valid = 1'b1;
    upd_index = 6'd9;
    upd_taken = 1'b1;
    #1;
    sb_push("rw_same_cycle", 1);
    sb_pop(int'(a_ctr));
    sb_push("index_plain", 9);
    sb_pop(int'(a_index));
    @(negedge clk);
    upd_valid = 1'b0;
    #1;
    sb_push("rw_next_cycle", 2);
    sb_pop(int'(a_ctr));

    // train index 3 to 3, then flush with a same-cycle update and a mid-sweep update
    @(negedge clk);
    pred_pc   = 6'd3;
    upd_index = 6'd3;
    upd_taken = 1'b1;
    upd_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    upd_valid = 1'b0;
    #1;
    sb_push("trained_idx3", 7);
    sb_pop(a_pred());
    @(negedge clk);
    flush     = 1'b1;
    upd_valid = 1'b1;
    upd_taken = 1'b0;
    @(negedge clk);
    flush     = 1'b0;
    upd_valid = 1'b0;
    count_busy(0, 10, cnt);
    sb_push("flush_sweep_len", 64);
    sb_pop(cnt);
    #1;
    sb_push("idx3_after_flush", 1);
    sb_pop(a_pred());

    // gshare history and index hash
    rst_g = 1'b1;
    @(negedge clk);
    rst_g = 1'b0;
    count_busy(1, -1, cnt);
    sb_push("gsh_sweep_len", 64);
    sb_pop(cnt);
    upd_index = 6'd0;
    for (int i = 0; i < 3; i++) begin
      upd_valid = 1'b1;
      upd_taken = (i < 2);
      @(negedge clk);
    end
    upd_valid = 1'b0;
    pred_pc   = 6'b000001;
    #1;
    sb_push("gsh_index", 7);
    sb_pop(int'(g_index));

    // reset twenty cycles into a sweep restarts it; an update in the sweep leaves ghr alone
    rst_g = 1'b1;
    @(negedge clk);
    rst_g = 1'b0;
    for (int i = 0; i < 20; i++) begin
      upd_valid = (i == 5);
      upd_taken = 1'b1;
      @(negedge clk);
    end
    upd_valid = 1'b0;
    sb_push("gsh_busy_mid", 1);
    sb_pop(int'(g_busy));
    rst_g = 1'b1;
    @(negedge clk);
    rst_g = 1'b0;
    count_busy(1, -1, cnt);
    sb_push("gsh_restart_len", 64);
    sb_pop(cnt);
    #1;
    sb_push("gsh_ghr_cleared", 1);
    sb_pop(int'(g_index));

    // single-bit counter behaviour
    rst_c = 1'b1;
    @(negedge clk);
    rst_c = 1'b0;
    count_busy(2, -1, cnt);
    sb_push("c1_sweep_len", 64);
    sb_pop(cnt);
    pred_pc = 6'd2;
    #1;
    sb_push("c1_init", 0);
    sb_pop(int'(c_taken));
    upd_index = 6'd2;
    upd_taken = 1'b1;
    upd_valid = 1'b1;
    @(negedge clk);
    upd_valid = 1'b0;
    #1;
    sb_push("c1_taken", 1);
    sb_pop(int'(c_taken));
    upd_taken = 1'b0;
    upd_valid = 1'b1;
    @(negedge clk);
    upd_valid = 1'b0;
    #1;
    sb_push("c1_not_taken", 0);
    sb_pop(int'(c_taken));

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_leftover: got %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
